nlms_serial_core: RTL and testbench

NLMS_SERIAL_CORE -- requirements
Module: nlms_serial_core

---
 rtl/nlms_pkg.sv | 37 +++
 rtl/nlms_sat_mac.sv | 31 +++
 rtl/nlms_serial_core.sv | 200 ++++++++++++++++++++
 tb/tb_nlms_serial_core.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nlms_pkg.sv
// Shared types and helpers for the serial NLMS core: FSM states,
// width derivation and signed saturation.
package nlms_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    FILTER,
    ERROR,
    UPDATE,
    DONE
  } state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Wide enough that summing NUM_TAPS full-scale products never overflows.
  function automatic int acc_width(input int dw, input int taps);
    return 2 * dw + clog2(taps);
  endfunction

  // Clamp a signed value to the range of a w-bit two's complement number (w <= 63).
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nlms_sat_mac.sv
// Single signed multiplier with arithmetic post-shift and saturating add;
// time-shared between the FIR accumulation and the weight update.
module nlms_sat_mac
  import nlms_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ACC_W = 35,
  parameter int SH_W  = 7
) (
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  input  logic        [SH_W-1:0]  sh_i,
  input  logic signed [ACC_W-1:0] add_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [DW-1:0]    w_o
);

  logic signed [2*DW-1:0] prod_d;
  logic signed [2*DW-1:0] prod_sh_d;
  logic signed [63:0]     sum_d;

  always_comb begin
    prod_d    = a_i * b_i;
    prod_sh_d = prod_d >>> sh_i;
    sum_d     = 64'(add_i) + 64'(prod_sh_d);
  end

  assign acc_o = ACC_W'(sat_s(sum_d, ACC_W));
  assign w_o   = DW'(sat_s(sum_d, DW));

endmodule

// File: rtl/nlms_serial_core.sv
// Serial normalised-LMS adaptive FIR: one MAC per cycle for filtering and
// for the power-normalised weight update, sequenced by a single FSM.
module nlms_serial_core
  import nlms_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 128,
  parameter int MU_SHIFT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         adapt_en,
  input  logic                         clear_w,
  input  logic signed [DATA_WIDTH-1:0] input_signal,
  input  logic signed [DATA_WIDTH-1:0] desired_signal,
  output logic                         idle,
  output logic                         ready,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic signed [DATA_WIDTH-1:0] e_out
);

  localparam int ACC_W = acc_width(DATA_WIDTH, NUM_TAPS);
  localparam int K_W   = clog2(NUM_TAPS);
  localparam int SH_W  = clog2(ACC_W) + 1;
  localparam int PAD_W = ACC_W - 2 * DATA_WIDTH;

  state_e                         state_q;
  logic        [K_W-1:0]          k_q;
  logic signed [DATA_WIDTH-1:0]   x_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]   w_q [NUM_TAPS];
  logic        [ACC_W-1:0]        p_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic signed [DATA_WIDTH-1:0]   xin_q;
  logic signed [DATA_WIDTH-1:0]   d_q;
  logic                           adapt_q;
  logic signed [DATA_WIDTH-1:0]   y_q;
  logic signed [DATA_WIDTH-1:0]   e_q;
  logic        [SH_W-1:0]         sh_q;
  logic signed [DATA_WIDTH-1:0]   y_out_q;
  logic signed [DATA_WIDTH-1:0]   e_out_q;
  logic                           ready_q;

  logic                           last_d;
  logic signed [DATA_WIDTH-1:0]   tap_x_d;
  logic signed [DATA_WIDTH-1:0]   tap_w_d;
  logic signed [DATA_WIDTH-1:0]   mac_a_d;
  logic        [SH_W-1:0]         mac_sh_d;
  logic signed [ACC_W-1:0]        mac_add_d;
  logic signed [ACC_W-1:0]        acc_d;
  logic signed [DATA_WIDTH-1:0]   w_upd_d;
  logic signed [2*DATA_WIDTH-1:0] xsq_d;
  logic signed [2*DATA_WIDTH-1:0] osq_d;
  logic        [ACC_W-1:0]        p_d;
  logic signed [ACC_W-1:0]        acc_sh_d;
  logic signed [DATA_WIDTH-1:0]   y_d;
  logic signed [DATA_WIDTH-1:0]   e_d;
  logic        [SH_W-1:0]         m_d;
  logic        [SH_W-1:0]         sh_d;
  int                             sh_int_d;

  assign last_d  = (k_q == K_W'(NUM_TAPS - 1));
  assign tap_x_d = x_q[k_q];
  assign tap_w_d = w_q[k_q];

  // FILTER accumulates w*x; UPDATE reuses the same multiplier for e*x onto w.
  always_comb begin
    mac_a_d   = tap_w_d;
    mac_sh_d  = '0;
    mac_add_d = acc_q;
    if (state_q == UPDATE) begin
      mac_a_d   = e_q;
      mac_sh_d  = sh_q;
      mac_add_d = {{(ACC_W - DATA_WIDTH){tap_w_d[DATA_WIDTH-1]}}, tap_w_d};
    end
  end

  nlms_sat_mac #(
    .DW   (DATA_WIDTH),
    .ACC_W(ACC_W),
    .SH_W (SH_W)
  ) u_mac (
    .a_i  (mac_a_d),
    .b_i  (tap_x_d),
    .sh_i (mac_sh_d),
    .add_i(mac_add_d),
    .acc_o(acc_d),
    .w_o  (w_upd_d)
  );

  // Running power stays exact: the departing sample's square is always inside P.
  always_comb begin
    xsq_d = xin_q * xin_q;
    osq_d = x_q[NUM_TAPS-1] * x_q[NUM_TAPS-1];
    p_d   = p_q + {{PAD_W{1'b0}}, xsq_d} - {{PAD_W{1'b0}}, osq_d};
  end

  always_comb begin
    acc_sh_d = acc_q >>> (DATA_WIDTH - 1);
    y_d      = DATA_WIDTH'(sat_s(64'(acc_sh_d), DATA_WIDTH));
    e_d      = DATA_WIDTH'(sat_s(64'(d_q) - 64'(y_d), DATA_WIDTH));
    m_d      = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (p_q[i]) m_d = SH_W'(i);
    end
    sh_int_d = int'(m_d) - (DATA_WIDTH - 1) + MU_SHIFT;
    sh_d     = (sh_int_d > 0) ? SH_W'(sh_int_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      p_q     <= '0;
      acc_q   <= '0;
      xin_q   <= '0;
      d_q     <= '0;
      adapt_q <= 1'b0;
      y_q     <= '0;
      e_q     <= '0;
      sh_q    <= '0;
      y_out_q <= '0;
      e_out_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_w) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
              x_q[i] <= '0;
              w_q[i] <= '0;
            end
            p_q <= '0;
          end
          if (start) begin
            xin_q   <= input_signal;
            d_q     <= desired_signal;
            adapt_q <= adapt_en;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          x_q[0] <= xin_q;
          for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
          p_q     <= p_d;
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= FILTER;
        end
        FILTER: begin
          acc_q <= acc_d;
          if (last_d) begin
            k_q     <= '0;
            state_q <= ERROR;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ERROR: begin
          y_q  <= y_d;
          e_q  <= e_d;
          sh_q <= sh_d;
          if (adapt_q) begin
            state_q <= UPDATE;
          end else begin
            y_out_q <= y_d;
            e_out_q <= e_d;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        UPDATE: begin
          w_q[k_q] <= w_upd_d;
          if (last_d) begin
            k_q     <= '0;
            y_out_q <= y_q;
            e_out_q <= e_q;
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idle  = (state_q == IDLE);
  assign ready = ready_q;
  assign y_out = y_out_q;
  assign e_out = e_out_q;

endmodule

// File: tb/tb_nlms_serial_core.sv
// Bench for nlms_serial_core (8 taps, Q1.15, mu = 1/4): vector table plus
// hand sequences for busy-start, clear and mid-update reset.
module tb_nlms_serial_core;

  localparam int NT      = 8;
  localparam int LAT_ADP = 2 * NT + 3;
  localparam int LAT_NOA = NT + 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        adapt_en;
  logic        clear_w;
  logic [15:0] input_signal;
  logic [15:0] desired_signal;
  logic        idle;
  logic        ready;
  logic [15:0] y_out;
  logic [15:0] e_out;

  nlms_serial_core #(
    .DATA_WIDTH(16),
    .NUM_TAPS  (NT),
    .MU_SHIFT  (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .adapt_en      (adapt_en),
    .clear_w       (clear_w),
    .input_signal  (input_signal),
    .desired_signal(desired_signal),
    .idle          (idle),
    .ready         (ready),
    .y_out         (y_out),
    .e_out         (e_out)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] d;
    logic        adapt;
    logic [15:0] y;
    logic [15:0] e;
  } vec_t;

  typedef struct {
    logic [15:0] y;
    logic [15:0] e;
    int          start_cyc;
    int          lat;
  } exp_t;

  vec_t vt[6];
  exp_t sb[$];
  int   n_vec;
  int   n_miss;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        $display("txn @%0d: y=%04h e=%04h latency=%0d", cyc, y_out, e_out, cyc - ex.start_cyc);
        check("y_out", y_out, ex.y);
        check("e_out", e_out, ex.e);
        check("latency", cyc - ex.start_cyc, ex.lat);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] d, input logic a,
                      input logic cw, input bit push, input logic [15:0] ey,
                      input logic [15:0] ee);
    exp_t ex;
    @(negedge clk);
    input_signal   = x;
    desired_signal = d;
    adapt_en       = a;
    clear_w        = cw;
    start          = 1'b1;
    if (push) begin
      ex.y         = ey;
      ex.e         = ee;
      ex.start_cyc = cyc;
      ex.lat       = a ? LAT_ADP : LAT_NOA;
      sb.push_back(ex);
    end
    @(negedge clk);
    start   = 1'b0;
    clear_w = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("ready_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    n_vec          = 0;
    n_miss         = 0;
    rst            = 1'b0;
    start          = 1'b0;
    adapt_en       = 1'b0;
    clear_w        = 1'b0;
    input_signal   = '0;
    desired_signal = '0;

    // Weight evolution: w0=1000 -> (1600,0600) -> (F600,E600,E000), then frozen.
    vt[0] = '{16'h4000, 16'h2000, 1'b1, 16'h0000, 16'h2000};
    vt[1] = '{16'h4000, 16'h2000, 1'b1, 16'h0800, 16'h1800};
    vt[2] = '{16'h4000, 16'h8000, 1'b1, 16'h0E00, 16'h8000};
    vt[3] = '{16'h4000, 16'h0000, 1'b0, 16'hDE00, 16'h2200};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'hE300, 16'h1D00};
    vt[5] = '{16'h0000, 16'h7FFF, 1'b0, 16'hF000, 16'h7FFF};

    repeat (3) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_ready", ready, 0);
    check("rst_y", y_out, 0);
    check("rst_e", e_out, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(vt[i].x, vt[i].d, vt[i].adapt, 1'b0, 1'b1, vt[i].y, vt[i].e);
      wait_done();
    end

    // start and clear_w while busy must both be dropped.
    send(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    start          = 1'b1;
    clear_w        = 1'b1;
    adapt_en       = 1'b1;
    input_signal   = 16'h4000;
    desired_signal = 16'h1111;
    @(negedge clk);
    start   = 1'b0;
    clear_w = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    send(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFB00, 16'h0500);
    wait_done();

    // clear_w alone stays in IDLE and zeroes the weights.
    @(negedge clk);
    clear_w = 1'b1;
    @(negedge clk);
    clear_w = 1'b0;
    check("clear_idle", idle, 1);
    check("clear_ready", ready, 0);
    send(16'h4000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    wait_done();

    // start with clear_w: P restarts from zero, so the step sizes repeat the first run.
    send(16'h4000, 16'h2000, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h2000);
    wait_done();
    send(16'h4000, 16'h2000, 1'b1, 1'b0, 1'b1, 16'h0800, 16'h1800);
    wait_done();
    send(16'h4000, 16'h2000, 1'b1, 1'b0, 1'b1, 16'h0E00, 16'h1200);
    wait_done();

    // Reset in the middle of UPDATE.
    send(16'h4000, 16'h2000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle_async", idle, 1);
    @(negedge clk);
    check("midrst_idle", idle, 1);
    check("midrst_ready", ready, 0);
    check("midrst_y", y_out, 0);
    check("midrst_e", e_out, 0);
    rst = 1'b1;
    send(16'h4000, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
    wait_done();

    repeat (30) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
